// File: rtl/config_chain_loader.sv
// Configuration chain loader: clears a single-bit scan chain, then serialises
// bitstream words (LSB first) onto the chain head with one enabled shift per bit.
module config_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              chain_rst,
   output logic              chain_shift_en,
   output logic              chain_head,
   output logic              busy,
   output logic              done
);

   localparam int WB_W  = $clog2(WORD_W + 1);
   localparam int CMP_W = (CNT_W > WB_W) ? CNT_W : WB_W;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [WB_W-1:0]   word_bits_q, word_bits_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;

   // The last word may be partial: only the bits still owed to the chain are shifted.
   logic [CMP_W-1:0] rem_ext, word_ext;
   logic [WB_W-1:0]  first_bits;

   assign rem_ext    = CMP_W'(remaining_q);
   assign word_ext   = CMP_W'(WORD_W);
   assign first_bits = (rem_ext < word_ext) ? WB_W'(rem_ext) : WB_W'(word_ext);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      remaining_d = remaining_q;
      word_bits_d = word_bits_q;
      sreg_d      = sreg_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            remaining_d = CHAIN_LEN_C;
            state_d     = S_FETCH;
         end
         S_FETCH: begin
            if (cfg_valid) begin
               sreg_d      = cfg_word;
               word_bits_d = first_bits;
               state_d     = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sreg_d      = sreg_q >> 1;
            word_bits_d = word_bits_q - WB_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1))      state_d = S_DONE;
            else if (word_bits_q == WB_W'(1))  state_d = S_FETCH;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         word_bits_q <= '0;
         sreg_q      <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         word_bits_q <= word_bits_d;
         sreg_q      <= sreg_d;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign chain_rst      = (state_q == S_CLEAR);
   assign cfg_ready      = (state_q == S_FETCH);
   assign chain_shift_en = (state_q == S_SHIFT);
   assign chain_head     = (state_q == S_SHIFT) & sreg_q[0];
   assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench for config_chain_loader: a 20-FF chain (WORD_W=8) and a 3-FF chain.
module tb_config_chain_loader;

   logic clk = 1'b0;
   logic reset;

   logic       a_start, a_valid;
   logic [7:0] a_word;
   logic       a_ready, a_rst, a_sh, a_head, a_busy, a_done;

   logic       b_start, b_valid;
   logic [7:0] b_word;
   logic       b_ready, b_rst, b_sh, b_head, b_busy, b_done;

   int checks = 0;
   int errors = 0;

   logic        sb_a[$];
   logic        sb_b[$];
   logic [19:0] chain_a = '0;

   always #5 clk = ~clk;

   config_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .cfg_word(a_word), .cfg_valid(a_valid),
      .cfg_ready(a_ready), .chain_rst(a_rst), .chain_shift_en(a_sh), .chain_head(a_head),
      .busy(a_busy), .done(a_done)
   );

   config_chain_loader #(.CHAIN_LEN(3), .WORD_W(8)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .cfg_word(b_word), .cfg_valid(b_valid),
      .cfg_ready(b_ready), .chain_rst(b_rst), .chain_shift_en(b_sh), .chain_head(b_head),
      .busy(b_busy), .done(b_done)
   );

   // Behavioural model of the fabric chain: head enters position 0, first bit ends at 19.
   always @(posedge clk) begin
      if (a_rst)     chain_a <= '0;
      else if (a_sh) chain_a <= {chain_a[18:0], a_head};
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drives one load on the 20-FF DUT from an IDLE negedge; returns at the IDLE negedge after done.
   task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int stall_len, input bit noise, input int exp_done,
                           input string name);
      logic [7:0]  words[3];
      logic [19:0] exp_chain;
      logic        exp_b;
      int cyc = 0, shifts = 0, hs = 0, dones = 0, done_cyc = -1;
      int stall_cnt = 0, word_idx = 0, bits_left = 20, k = 0;
      bit fin = 0;
      words = '{w0, w1, w2};
      exp_chain = '0;
      for (int i = 0; i < 3; i++)
         for (int b = 0; b < 8; b++)
            if (k < 20) begin exp_chain[19-k] = words[i][b]; k++; end
      sb_a.delete();
      a_start = 1'b1; a_valid = 1'b1; a_word = words[0];
      while (!fin) begin
         @(negedge clk);
         cyc++;
         a_start = 1'b0;
         if (cyc > 80) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within 80 cycles (shifts=%0d)", name, shifts);
            fin = 1;
         end else if (dones > 0) begin
            checks++;
            if (a_busy !== 1'b0 || a_done !== 1'b0) begin
               errors++;
               $display("FAIL %s after_done: busy=%b done=%b, required 0 0", name, a_busy, a_done);
            end
            fin = 1;
         end else begin
            checks++;
            if (a_busy !== 1'b1) begin
               errors++; $display("FAIL %s busy cyc %0d: got %b, required 1", name, cyc, a_busy);
            end
            checks++;
            if (a_rst !== (cyc == 1)) begin
               errors++; $display("FAIL %s chain_rst cyc %0d: got %b, required %b", name, cyc, a_rst, cyc == 1);
            end
            if (word_idx == 1 && stall_cnt > 0) begin
               checks++;
               if (a_ready !== 1'b1 || a_sh !== 1'b0) begin
                  errors++;
                  $display("FAIL %s stall cyc %0d: ready=%b shift_en=%b, required 1 0", name, cyc, a_ready, a_sh);
               end
            end
            checks++;
            if (a_sh === 1'b1) begin
               if (sb_a.size() == 0) begin
                  errors++; $display("FAIL %s extra_shift cyc %0d: shift with empty scoreboard", name, cyc);
               end else begin
                  exp_b = sb_a.pop_front();
                  if (a_head !== exp_b) begin
                     errors++; $display("FAIL %s head cyc %0d: got %b, required %b", name, cyc, a_head, exp_b);
                  end
               end
               shifts++;
               if (noise && shifts == 4) a_start = 1'b1;
            end else if (a_head !== 1'b0) begin
               errors++; $display("FAIL %s head_idle cyc %0d: got %b, required 0", name, cyc, a_head);
            end
            if (a_done === 1'b1) begin
               dones++; done_cyc = cyc;
               if (noise) a_start = 1'b1;
            end
            if (a_ready === 1'b1 && word_idx == 1 && stall_cnt < stall_len) begin
               a_valid = 1'b0; stall_cnt++;
            end else begin
               a_valid = 1'b1;
            end
            a_word = (word_idx < 3) ? words[word_idx] : 8'($urandom);
            if (a_ready === 1'b1 && a_valid) begin
               hs++;
               for (int b = 0; b < 8; b++)
                  if (bits_left > 0) begin sb_a.push_back(a_word[b]); bits_left--; end
               word_idx++;
            end
         end
      end
      a_valid = 1'b0;
      checks++;
      if (shifts != 20) begin errors++; $display("FAIL %s shift_count: got %0d, required 20", name, shifts); end
      checks++;
      if (hs != 3) begin errors++; $display("FAIL %s handshakes: got %0d, required 3", name, hs); end
      checks++;
      if (done_cyc != exp_done) begin errors++; $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc, exp_done); end
      checks++;
      if (chain_a !== exp_chain) begin errors++; $display("FAIL %s chain: got %h, required %h", name, chain_a, exp_chain); end
      checks++;
      if (sb_a.size() != 0) begin errors++; $display("FAIL %s leftover_bits: got %0d, required 0", name, sb_a.size()); end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(2);
      checks++;
      if ({a_ready, a_rst, a_sh, a_head, a_busy, a_done} !== 6'b0) begin
         errors++; $display("FAIL reset_a outputs: got %b, required 000000", {a_ready, a_rst, a_sh, a_head, a_busy, a_done});
      end
      checks++;
      if ({b_ready, b_rst, b_sh, b_head, b_busy, b_done} !== 6'b0) begin
         errors++; $display("FAIL reset_b outputs: got %b, required 000000", {b_ready, b_rst, b_sh, b_head, b_busy, b_done});
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_nominal;
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 25, "nominal");
      checks++;
      if (chain_a !== 20'hA53CF) begin errors++; $display("FAIL nominal chain_const: got %h, required a53cf", chain_a); end
      idle(2);
   endtask

   task automatic test_stall;
      run_load(8'hA5, 8'h3C, 8'h0F, 5, 1'b0, 30, "stall");
      checks++;
      if (chain_a !== 20'hA53CF) begin errors++; $display("FAIL stall chain_const: got %h, required a53cf", chain_a); end
      idle(2);
   endtask

   task automatic test_short_chain;
      logic exp_b;
      int cyc = 0, shifts = 0, hs = 0, done_cyc = -1, bits_left = 3;
      bit fin = 0;
      sb_b.delete();
      b_start = 1'b1; b_valid = 1'b1; b_word = 8'hFE;
      while (!fin && cyc < 30) begin
         @(negedge clk);
         cyc++;
         b_start = 1'b0;
         if (b_sh === 1'b1) begin
            checks++;
            exp_b = (sb_b.size() != 0) ? sb_b.pop_front() : 1'bx;
            if (b_head !== exp_b) begin errors++; $display("FAIL short head cyc %0d: got %b, required %b", cyc, b_head, exp_b); end
            shifts++;
         end
         if (b_ready === 1'b1) begin
            hs++;
            for (int b = 0; b < 8; b++)
               if (bits_left > 0) begin sb_b.push_back(b_word[b]); bits_left--; end
         end
         if (b_done === 1'b1) begin done_cyc = cyc; fin = 1; end
      end
      idle(3);
      b_valid = 1'b0;
      checks++;
      if (hs != 1) begin errors++; $display("FAIL short handshakes: got %0d, required 1", hs); end
      checks++;
      if (shifts != 3) begin errors++; $display("FAIL short shift_count: got %0d, required 3", shifts); end
      checks++;
      if (done_cyc != 6) begin errors++; $display("FAIL short done_cycle: got %0d, required 6", done_cyc); end
      checks++;
      if (b_busy !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL short idle_after: busy=%b ready=%b, required 0 0", b_busy, b_ready);
      end
   endtask

   task automatic test_reset_mid;
      int cyc = 0, shifts = 0, late_done = 0;
      a_start = 1'b1; a_valid = 1'b1; a_word = 8'hA5;
      while (shifts < 10 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         a_start = 1'b0;
         if (a_sh === 1'b1) shifts++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      a_valid = 1'b0;
      checks++;
      if ({a_ready, a_rst, a_sh, a_head, a_busy, a_done} !== 6'b0) begin
         errors++; $display("FAIL reset_mid outputs: got %b, required 000000 (shifts seen %0d)",
                            {a_ready, a_rst, a_sh, a_head, a_busy, a_done}, shifts);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (a_done === 1'b1 || a_busy === 1'b1) late_done++;
      end
      checks++;
      if (late_done != 0) begin errors++; $display("FAIL reset_mid quiet: got %0d active cycles, required 0", late_done); end
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 25, "reload");
      idle(2);
   endtask

   task automatic test_ignored;
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b1, 25, "ignored");
      idle(2);
   endtask

   task automatic test_back_to_back;
      run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 25, "b2b_run1");
      run_load(8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 25, "b2b_run2");
      checks++;
      if (chain_a !== 20'hFFFFF) begin errors++; $display("FAIL b2b chain_const: got %h, required fffff", chain_a); end
      idle(2);
   endtask

   initial begin
      reset = 1'b1;
      a_start = 1'b0; a_valid = 1'b0; a_word = '0;
      b_start = 1'b0; b_valid = 1'b0; b_word = '0;
      @(negedge clk);
      test_reset();
      test_nominal();
      test_stall();
      test_short_chain();
      test_reset_mid();
      test_ignored();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
